// File: rtl/sub64_pipe_if.sv
// Operand/result streaming bundle for the pipelined 64-bit subtractor.
// The upstream side drives operands, and the downstream side drives out_ready.
interface sub64_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] D;
    logic        bout;
    logic        ovf;
    logic        zero;

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output D,
        output bout,
        output ovf,
        output zero
    );

    modport master (
        output in_valid,
        output A,
        output B,
        output bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  D,
        input  bout,
        input  ovf,
        input  zero
    );
endinterface

// File: rtl/sub64_pipe.sv
// Four-stage 64-bit subtractor: one 16-bit slice per stage, borrow carried in registers.
// Stage 3 holds the final D/bout/ovf/zero, so outputs come straight from flops.
module sub64_pipe (
    input  logic         clk,
    input  logic         rst_n,
    sub64_pipe_if.slave  bus
);

    localparam int WIDTH = 64;
    localparam int SLICE = 16;
    localparam int NST   = WIDTH / SLICE;

    // {carry_out, sum} of a + ~b + c over one slice
    function automatic logic [SLICE:0] slice_sub(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             c
    );
        return {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, c};
    endfunction

    logic [NST-1:0] v_q;
    logic [NST-1:0] v_d;
    logic [NST-1:0] ld;
    logic [NST-1:0] src_v;
    logic [NST-1:0] en;

    logic [47:0] a0_q, a0_d;
    logic [47:0] b0_q, b0_d;
    logic [15:0] d0_q, d0_d;
    logic        c0_q, c0_d;
    logic        z0_q, z0_d;

    logic [31:0] a1_q, a1_d;
    logic [31:0] b1_q, b1_d;
    logic [31:0] d1_q, d1_d;
    logic        c1_q, c1_d;
    logic        z1_q, z1_d;

    logic [15:0] a2_q, a2_d;
    logic [15:0] b2_q, b2_d;
    logic [47:0] d2_q, d2_d;
    logic        c2_q, c2_d;
    logic        z2_q, z2_d;

    logic [63:0] d3_q, d3_d;
    logic        bout_q, bout_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;

    logic [SLICE:0] s0, s1, s2, s3;

    // Ready chain: a stage may load when empty or when its successor loads
    always_comb begin
        ld[3] = ~v_q[3] | bus.out_ready;
        ld[2] = ~v_q[2] | ld[3];
        ld[1] = ~v_q[1] | ld[2];
        ld[0] = ~v_q[0] | ld[1];
    end

    assign src_v = {v_q[2:0], bus.in_valid};
    assign en    = ld & src_v;

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < NST; k++) begin
            if (ld[k]) v_d[k] = src_v[k];
        end
    end

    always_comb begin
        s0   = slice_sub(bus.A[15:0], bus.B[15:0], ~bus.bin);
        a0_d = bus.A[63:16];
        b0_d = bus.B[63:16];
        d0_d = s0[15:0];
        c0_d = s0[16];
        z0_d = (s0[15:0] == '0);
    end

    always_comb begin
        s1   = slice_sub(a0_q[15:0], b0_q[15:0], c0_q);
        a1_d = a0_q[47:16];
        b1_d = b0_q[47:16];
        d1_d = {s1[15:0], d0_q};
        c1_d = s1[16];
        z1_d = z0_q & (s1[15:0] == '0);
    end

    always_comb begin
        s2   = slice_sub(a1_q[15:0], b1_q[15:0], c1_q);
        a2_d = a1_q[31:16];
        b2_d = b1_q[31:16];
        d2_d = {s2[15:0], d1_q};
        c2_d = s2[16];
        z2_d = z1_q & (s2[15:0] == '0);
    end

    // Top slice also resolves the borrow-out and signed overflow
    always_comb begin
        s3     = slice_sub(a2_q, b2_q, c2_q);
        d3_d   = {s3[15:0], d2_q};
        bout_d = ~s3[16];
        ovf_d  = (a2_q[15] ^ b2_q[15]) & (s3[15] ^ a2_q[15]);
        zero_d = z2_q & (s3[15:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q <= '0;
            b0_q <= '0;
            d0_q <= '0;
            c0_q <= 1'b0;
            z0_q <= 1'b0;
        end else if (en[0]) begin
            a0_q <= a0_d;
            b0_q <= b0_d;
            d0_q <= d0_d;
            c0_q <= c0_d;
            z0_q <= z0_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q <= '0;
            b1_q <= '0;
            d1_q <= '0;
            c1_q <= 1'b0;
            z1_q <= 1'b0;
        end else if (en[1]) begin
            a1_q <= a1_d;
            b1_q <= b1_d;
            d1_q <= d1_d;
            c1_q <= c1_d;
            z1_q <= z1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2_q <= '0;
            b2_q <= '0;
            d2_q <= '0;
            c2_q <= 1'b0;
            z2_q <= 1'b0;
        end else if (en[2]) begin
            a2_q <= a2_d;
            b2_q <= b2_d;
            d2_q <= d2_d;
            c2_q <= c2_d;
            z2_q <= z2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d3_q   <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en[3]) begin
            d3_q   <= d3_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[3];
    assign bus.D         = d3_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sub64_pipe.sv
// Scoreboard bench for sub64_pipe: directed vectors with hand-computed results.
// The driver queues expectations on acceptance; a negedge monitor pops and compares.
module tb_sub64_pipe;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk;
    logic rst_n;
    sub64_pipe_if bus_if ();

    sub64_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t q[$];
    vec_t vecs[17];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;

    logic        stall_prev = 1'b0;
    logic [63:0] d_prev;
    logic [2:0]  f_prev;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop plus stall-stability check
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(bus_if.out_valid), 64'd1);
                chk("stall_D", bus_if.D, d_prev);
                chk("stall_flags",
                    64'({bus_if.bout, bus_if.ovf, bus_if.zero}),
                    64'(f_prev));
            end
            stall_prev <= bus_if.out_valid & ~bus_if.out_ready;
            d_prev     <= bus_if.D;
            f_prev     <= {bus_if.bout, bus_if.ovf, bus_if.zero};
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got D=%h expected none",
                             bus_if.D);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    n_vec++;
                    chk("D", bus_if.D, e.d);
                    chk("bout", 64'(bus_if.bout), 64'(e.bout));
                    chk("ovf", 64'(bus_if.ovf), 64'(e.ovf));
                    chk("zero", 64'(bus_if.zero), 64'(e.zero));
                end
            end
        end
    end

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.A        = v.a;
        bus_if.B        = v.b;
        bus_if.bin      = v.bin;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                q.push_back(v);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b1, 1'b0, 1'b0};
        vecs[2]  = '{64'h0001_0000_0000_0000, 64'd1, 1'b0,
                     64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                     1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b1, 1'b0, 1'b0};
        vecs[6]  = '{64'd10, 64'd20, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6,
                     1'b1, 1'b0, 1'b0};
        vecs[7]  = '{64'd100, 64'd1, 1'b1, 64'd98, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{64'h0000_0001_0000_0000, 64'd1, 1'b1,
                     64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000,
                     1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001,
                     1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{64'hDEAD_BEEF_0000_0000, 64'd1, 1'b0,
                     64'hDEAD_BEEE_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{64'd9, 64'd4, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{64'd3, 64'd3, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{64'd50, 64'd8, 1'b0, 64'd42, 1'b0, 1'b0, 1'b0};

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.A         = '0;
        bus_if.B         = '0;
        bus_if.bin       = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_D", bus_if.D, 64'd0);
        chk("rst_bout", 64'(bus_if.bout), 64'd0);
        chk("rst_ovf", 64'(bus_if.ovf), 64'd0);
        chk("rst_zero", 64'(bus_if.zero), 64'd0);
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single op: out_valid only on the 4th cycle after acceptance
        send(vecs[0]);
        bus_if.in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("latency_c%0d", i), 64'(bus_if.out_valid),
                (i == 4) ? 64'd1 : 64'd0);
        end
        @(posedge clk);
        #1;

        for (int i = 1; i <= 5; i++) send(vecs[i]);
        bus_if.in_valid = 1'b0;
        drain();

        // Eight back-to-back ops against a stalled then toggling sink
        fork
            begin
                bus_if.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus_if.out_ready = 1'b1;
                @(posedge clk); #1 bus_if.out_ready = 1'b0;
                @(posedge clk); #1 bus_if.out_ready = 1'b1;
                @(posedge clk); #1 bus_if.out_ready = 1'b0;
                @(posedge clk); #1 bus_if.out_ready = 1'b1;
            end
            begin
                for (int i = 6; i <= 9; i++) send(vecs[i]);
                @(negedge clk);
                chk("full_in_ready", 64'(bus_if.in_ready), 64'd0);
                for (int i = 10; i <= 13; i++) send(vecs[i]);
                bus_if.in_valid = 1'b0;
            end
        join
        drain();

        // Reset with two ops in flight: neither may ever emerge
        send(vecs[14]);
        send(vecs[15]);
        bus_if.in_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(bus_if.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(vecs[16]);
        bus_if.in_valid = 1'b0;
        drain();

        chk("vectors_seen", 64'(n_vec), 64'd15);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
